// File: rtl/jts16_tmap_arb_if.sv
// Tilemap-fetcher / SDRAM bundle for jts16_tmap_arb.
// The arbiter uses the slave modport; requesters and SDRAM use master.
interface jts16_tmap_arb_if #(
    parameter int AW = 22,
    parameter int DW = 32
);
    logic [4:0]    req_cs;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [AW-1:0] req_addr2;
    logic [AW-1:0] req_addr3;
    logic [AW-1:0] req_addr4;
    logic [4:0]    req_ok;
    logic [DW-1:0] req_data0;
    logic [DW-1:0] req_data1;
    logic [DW-1:0] req_data2;
    logic [DW-1:0] req_data3;
    logic [DW-1:0] req_data4;
    logic [AW-1:0] sd_addr;
    logic          sd_rd;
    logic          sd_ack;
    logic          sd_rdy;
    logic [DW-1:0] sd_din;
    logic          busy;

    modport master (
        output req_cs, req_addr0, req_addr1, req_addr2, req_addr3, req_addr4,
        output sd_ack, sd_rdy, sd_din,
        input  req_ok, req_data0, req_data1, req_data2, req_data3, req_data4,
        input  sd_addr, sd_rd, busy
    );

    modport slave (
        input  req_cs, req_addr0, req_addr1, req_addr2, req_addr3, req_addr4,
        input  sd_ack, sd_rdy, sd_din,
        output req_ok, req_data0, req_data1, req_data2, req_data3, req_data4,
        output sd_addr, sd_rd, busy
    );
endinterface

// File: rtl/jts16_tmap_arb.sv
// Five-way SDRAM read arbiter for the tilemap fetchers, with a one-entry
// tag cache per requester and round-robin (or fixed priority) miss service.
module jts16_tmap_arb #(
    parameter int AW = 22,
    parameter int DW = 32,
    parameter bit RR = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    jts16_tmap_arb_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr   [5];
    logic [AW-1:0] tag_q  [5];
    logic [AW-1:0] tag_d  [5];
    logic [DW-1:0] data_q [5];
    logic [DW-1:0] data_d [5];
    logic [4:0]    v_q, v_d, ok_q, ok_d, hit, miss;
    logic [2:0]    gnt_q, gnt_d, rr_q, rr_d, win;
    logic [3:0]    rr_base, idx;
    logic          win_vld;
    logic [AW-1:0] sd_addr_q, sd_addr_d;

    always_comb begin
        addr[0] = bus.req_addr0;
        addr[1] = bus.req_addr1;
        addr[2] = bus.req_addr2;
        addr[3] = bus.req_addr3;
        addr[4] = bus.req_addr4;
    end

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            hit[i] = bus.req_cs[i] & v_q[i] & (tag_q[i] == addr[i]);
        end
        miss = bus.req_cs & ~hit;
    end

    // Scan five slots starting at the pointer (or at 0 for fixed priority).
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        rr_base = RR ? {1'b0, rr_q} : '0;
        for (int unsigned k = 0; k < 5; k++) begin
            idx = rr_base + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!win_vld && miss[idx]) begin
                win     = idx[2:0];
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            v_q       <= '0;
            ok_q      <= '0;
            gnt_q     <= '0;
            rr_q      <= '0;
            sd_addr_q <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            ok_q      <= ok_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            sd_addr_q <= sd_addr_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_vld)     state_d = S_ISSUE;
            S_ISSUE: if (bus.sd_ack)  state_d = S_WAIT;
            S_WAIT:  if (bus.sd_rdy)  state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        v_d       = v_q;
        tag_d     = tag_q;
        data_d    = data_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        sd_addr_d = sd_addr_q;
        ok_d      = hit;
        if (state_q == S_IDLE && win_vld) begin
            gnt_d      = win;
            sd_addr_d  = addr[win];
            v_d[win]   = 1'b0;
        end
        // The tag is the address actually fetched, not the live request.
        if (state_q == S_WAIT && bus.sd_rdy) begin
            data_d[gnt_q] = bus.sd_din;
            tag_d[gnt_q]  = sd_addr_q;
            v_d[gnt_q]    = 1'b1;
            rr_d          = (gnt_q == 3'd4) ? 3'd0 : gnt_q + 3'd1;
        end
    end

    assign bus.sd_rd     = (state_q == S_ISSUE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.sd_addr   = sd_addr_q;
    assign bus.req_ok    = ok_q;
    assign bus.req_data0 = data_q[0];
    assign bus.req_data1 = data_q[1];
    assign bus.req_data2 = data_q[2];
    assign bus.req_data3 = data_q[3];
    assign bus.req_data4 = data_q[4];
endmodule

// File: tb/tb_jts16_tmap_arb.sv
// Directed bench for jts16_tmap_arb: a cycle table for the miss/hit path and
// hand sequences for arbitration order, in-flight address change and reset.
module tb_jts16_tmap_arb;
    logic clk = 1'b0;
    logic rst_n;
    logic ack, rdy, sel;
    logic [31:0] din;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jts16_tmap_arb_if #(.AW(22), .DW(32)) u_if ();
    jts16_tmap_arb_if #(.AW(22), .DW(32)) f_if ();

    jts16_tmap_arb #(.AW(22), .DW(32), .RR(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(u_if.slave));
    jts16_tmap_arb #(.AW(22), .DW(32), .RR(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n), .bus(f_if.slave));

    assign u_if.sd_ack = ack;
    assign u_if.sd_rdy = rdy;
    assign u_if.sd_din = din;
    assign f_if.sd_ack = ack;
    assign f_if.sd_rdy = rdy;
    assign f_if.sd_din = din;

    logic        rd_mon;
    logic [21:0] addr_mon;
    assign rd_mon   = sel ? f_if.sd_rd : u_if.sd_rd;
    assign addr_mon = sel ? f_if.sd_addr : u_if.sd_addr;

    typedef struct {
        logic        cs0;
        logic [21:0] a0;
        logic        ack;
        logic        rdy;
        logic [31:0] din;
        logic        e_rd;
        logic [21:0] e_addr;
        logic        e_busy;
        logic        e_ok;
        logic [31:0] e_data;
    } vec_t;

    vec_t tv [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ack = 1'b0; rdy = 1'b0; din = '0;
        u_if.req_cs = '0; f_if.req_cs = '0;
        u_if.req_addr0 = '0; u_if.req_addr1 = '0; u_if.req_addr2 = '0;
        u_if.req_addr3 = '0; u_if.req_addr4 = '0;
        f_if.req_addr0 = '0; f_if.req_addr1 = '0; f_if.req_addr2 = '0;
        f_if.req_addr3 = '0; f_if.req_addr4 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_rd(input logic [21:0] exp, input string nm);
        int unsigned n = 0;
        while (!rd_mon && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_rd"}, 64'(rd_mon), 64'd1);
        chk({nm, "_addr"}, 64'(addr_mon), 64'(exp));
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    task automatic do_rdy(input logic [31:0] d);
        rdy = 1'b1; din = d;
        @(posedge clk); #1;
        rdy = 1'b0; din = '0;
    endtask

    initial begin
        sel = 1'b0;
        tv[0]  = '{1'b1, 22'h1234, 1'b0, 1'b0, 32'h0,        1'b1, 22'h1234, 1'b1, 1'b0, 32'h0};
        tv[1]  = '{1'b1, 22'h1234, 1'b0, 1'b0, 32'h0,        1'b1, 22'h1234, 1'b1, 1'b0, 32'h0};
        tv[2]  = '{1'b1, 22'h1234, 1'b1, 1'b0, 32'h0,        1'b0, 22'h1234, 1'b1, 1'b0, 32'h0};
        tv[3]  = '{1'b1, 22'h1234, 1'b0, 1'b0, 32'h0,        1'b0, 22'h1234, 1'b1, 1'b0, 32'h0};
        tv[4]  = '{1'b1, 22'h1234, 1'b0, 1'b0, 32'h0,        1'b0, 22'h1234, 1'b1, 1'b0, 32'h0};
        tv[5]  = '{1'b1, 22'h1234, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 22'h1234, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[6]  = '{1'b1, 22'h1234, 1'b0, 1'b0, 32'h0,        1'b0, 22'h1234, 1'b0, 1'b1, 32'hDEADBEEF};
        tv[7]  = '{1'b1, 22'h1234, 1'b0, 1'b0, 32'h0,        1'b0, 22'h1234, 1'b0, 1'b1, 32'hDEADBEEF};
        tv[8]  = '{1'b1, 22'h1235, 1'b0, 1'b0, 32'h0,        1'b1, 22'h1235, 1'b1, 1'b0, 32'hDEADBEEF};
        tv[9]  = '{1'b1, 22'h1235, 1'b1, 1'b0, 32'h0,        1'b0, 22'h1235, 1'b1, 1'b0, 32'hDEADBEEF};
        tv[10] = '{1'b1, 22'h1235, 1'b0, 1'b1, 32'h11112222, 1'b0, 22'h1235, 1'b0, 1'b0, 32'h11112222};
        tv[11] = '{1'b1, 22'h1235, 1'b0, 1'b0, 32'h0,        1'b0, 22'h1235, 1'b0, 1'b1, 32'h11112222};
        tv[12] = '{1'b1, 22'h1235, 1'b0, 1'b0, 32'h0,        1'b0, 22'h1235, 1'b0, 1'b1, 32'h11112222};
        tv[13] = '{1'b1, 22'h1234, 1'b0, 1'b0, 32'h0,        1'b1, 22'h1234, 1'b1, 1'b0, 32'h11112222};
        tv[14] = '{1'b1, 22'h1234, 1'b1, 1'b0, 32'h0,        1'b0, 22'h1234, 1'b1, 1'b0, 32'h11112222};
        tv[15] = '{1'b1, 22'h1234, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 22'h1234, 1'b0, 1'b0, 32'hCAFEF00D};
        tv[16] = '{1'b1, 22'h1234, 1'b0, 1'b0, 32'h0,        1'b0, 22'h1234, 1'b0, 1'b1, 32'hCAFEF00D};
        tv[17] = '{1'b0, 22'h1234, 1'b0, 1'b0, 32'h0,        1'b0, 22'h1234, 1'b0, 1'b0, 32'hCAFEF00D};

        do_reset();
        chk("rst_sd_rd",   64'(u_if.sd_rd), 64'd0);
        chk("rst_sd_addr", 64'(u_if.sd_addr), 64'd0);
        chk("rst_busy",    64'(u_if.busy), 64'd0);
        chk("rst_ok",      64'(u_if.req_ok), 64'd0);
        chk("rst_data",    64'(u_if.req_data0 | u_if.req_data1 | u_if.req_data2 |
                              u_if.req_data3 | u_if.req_data4), 64'd0);

        for (int i = 0; i < 18; i++) begin
            u_if.req_cs    = {4'b0, tv[i].cs0};
            u_if.req_addr0 = tv[i].a0;
            ack = tv[i].ack; rdy = tv[i].rdy; din = tv[i].din;
            @(posedge clk); #1;
            chk($sformatf("tv%0d_rd", i),    64'(u_if.sd_rd),     64'(tv[i].e_rd));
            chk($sformatf("tv%0d_addr", i),  64'(u_if.sd_addr),   64'(tv[i].e_addr));
            chk($sformatf("tv%0d_busy", i),  64'(u_if.busy),      64'(tv[i].e_busy));
            chk($sformatf("tv%0d_ok", i),    64'(u_if.req_ok[0]), 64'(tv[i].e_ok));
            chk($sformatf("tv%0d_data", i),  64'(u_if.req_data0), 64'(tv[i].e_data));
        end
        ack = 1'b0; rdy = 1'b0; din = '0;

        // Round-robin: all five miss; requester 0 re-misses after its turn.
        do_reset();
        sel = 1'b0;
        u_if.req_addr0 = 22'h100; u_if.req_addr1 = 22'h101; u_if.req_addr2 = 22'h102;
        u_if.req_addr3 = 22'h103; u_if.req_addr4 = 22'h104;
        u_if.req_cs = 5'h1F;
        wait_rd(22'h100, "rr_g0"); do_ack(); do_rdy(32'h1000);
        u_if.req_addr0 = 22'h200;
        wait_rd(22'h101, "rr_g1"); do_ack(); do_rdy(32'h1001);
        wait_rd(22'h102, "rr_g2"); do_ack(); do_rdy(32'h1002);
        wait_rd(22'h103, "rr_g3"); do_ack(); do_rdy(32'h1003);
        wait_rd(22'h104, "rr_g4"); do_ack(); do_rdy(32'h1004);
        wait_rd(22'h200, "rr_g0b"); do_ack(); do_rdy(32'h2000);
        @(posedge clk); #1;
        chk("rr_ok_all", 64'(u_if.req_ok), 64'h1F);
        chk("rr_data0",  64'(u_if.req_data0), 64'h2000);
        chk("rr_data3",  64'(u_if.req_data3), 64'h1003);
        @(posedge clk); #1;
        chk("rr_idle_rd", 64'(u_if.sd_rd), 64'd0);

        // Fixed priority: 1 and 3 miss; 1 re-misses and still wins over 3.
        do_reset();
        sel = 1'b1;
        f_if.req_addr1 = 22'h300; f_if.req_addr3 = 22'h333;
        f_if.req_cs = 5'b01010;
        wait_rd(22'h300, "fp_first"); do_ack(); do_rdy(32'h3000);
        f_if.req_addr1 = 22'h301;
        wait_rd(22'h301, "fp_second"); do_ack(); do_rdy(32'h3001);
        wait_rd(22'h333, "fp_third"); do_ack(); do_rdy(32'h3333);
        @(posedge clk); #1;
        chk("fp_ok", 64'(f_if.req_ok), 64'b01010);
        chk("fp_data1", 64'(f_if.req_data1), 64'h3001);

        // Address change while its own fetch is in WAIT.
        do_reset();
        sel = 1'b0;
        u_if.req_addr2 = 22'h400;
        u_if.req_cs = 5'b00100;
        wait_rd(22'h400, "chg_old"); do_ack();
        u_if.req_addr2 = 22'h404;
        @(posedge clk); #1;
        chk("chg_busy", 64'(u_if.busy), 64'd1);
        do_rdy(32'hA5A5A5A5);
        chk("chg_data_old", 64'(u_if.req_data2), 64'hA5A5A5A5);
        @(posedge clk); #1;
        chk("chg_ok_stale", 64'(u_if.req_ok[2]), 64'd0);
        wait_rd(22'h404, "chg_new"); do_ack(); do_rdy(32'h5A5A5A5A);
        @(posedge clk); #1;
        chk("chg_ok_new", 64'(u_if.req_ok[2]), 64'd1);
        chk("chg_data_new", 64'(u_if.req_data2), 64'h5A5A5A5A);

        // Reset during WAIT, then a late sd_rdy must be ignored.
        do_reset();
        sel = 1'b0;
        u_if.req_addr0 = 22'h500;
        u_if.req_cs = 5'b00001;
        wait_rd(22'h500, "rst_fetch"); do_ack();
        chk("rst_wait_busy", 64'(u_if.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_busy", 64'(u_if.busy), 64'd0);
        chk("rst_async_rd",   64'(u_if.sd_rd), 64'd0);
        u_if.req_cs = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        do_rdy(32'h77777777);
        chk("rst_late_busy", 64'(u_if.busy), 64'd0);
        chk("rst_late_rd",   64'(u_if.sd_rd), 64'd0);
        chk("rst_late_ok",   64'(u_if.req_ok), 64'd0);
        chk("rst_late_data", 64'(u_if.req_data0), 64'd0);
        u_if.req_cs = 5'b00001;
        @(posedge clk); #1;
        chk("rst_refetch_rd", 64'(u_if.sd_rd), 64'd1);
        chk("rst_refetch_ok", 64'(u_if.req_ok[0]), 64'd0);
        do_ack(); do_rdy(32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
